// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory port arbiter: FSM state and transaction owner.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch port I, load/store port D) in front of one
// single-ported memory with a ReadEnable/WriteEnable + Ack handshake.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    // fetch port
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic              IAck,
    output logic [WIDTH-1:0]  IData,
    // load/store port
    input  logic              DReq,
    input  logic              DWrite,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [WIDTH-1:0]  DWData,
    output logic              DAck,
    output logic [WIDTH-1:0]  DRData,
    // memory side
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemReadEnable,
    output logic              MemWriteEnable,
    output logic [WIDTH-1:0]  MemWData,
    input  logic [WIDTH-1:0]  MemRData,
    input  logic              MemAck
);

    // Round-robin choice: on a conflict the side that was not served last wins.
    function automatic owner_t rr_pick(input logic iReq, input logic dReq,
                                       input owner_t lastGrant);
        owner_t pick;
        if (iReq && dReq)
            pick = (lastGrant == OWN_I) ? OWN_D : OWN_I;
        else if (dReq)
            pick = OWN_D;
        else
            pick = OWN_I;
        return pick;
    endfunction

    arb_state_t        r_state;
    owner_t            r_owner;
    owner_t            r_lastGrant;
    logic [ADDR_W-1:0] r_memAddr;
    logic [WIDTH-1:0]  r_memWData;
    logic              r_memRe;
    logic              r_memWe;
    logic              r_iAck;
    logic              r_dAck;
    logic [WIDTH-1:0]  r_iData;
    logic [WIDTH-1:0]  r_dRData;

    owner_t            w_pick;
    logic              w_grant;
    logic              w_done;

    assign w_pick  = rr_pick(IReq, DReq, r_lastGrant);
    assign w_grant = (r_state == IDLE) && (IReq || DReq);
    // MemAck is honoured only in WAIT, so stale or late pulses are dropped.
    assign w_done  = (r_state == WAIT) && MemAck;

    // Sequencer: state, current owner and the round-robin history.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_owner     <= OWN_I;
            r_lastGrant <= OWN_I;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_pick;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (w_done)
                        r_state <= RESP;
                end
                RESP: begin
                    r_lastGrant <= r_owner;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory interface: latch the winner's operands at grant, hold the enables
    // through ISSUE and WAIT, and drop them on the edge that leaves WAIT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_memAddr  <= '0;
            r_memWData <= '0;
            r_memRe    <= 1'b0;
            r_memWe    <= 1'b0;
        end else if (w_grant) begin
            if (w_pick == OWN_D) begin
                r_memAddr  <= DAddr;
                r_memWData <= DWData;
                r_memRe    <= ~DWrite;
                r_memWe    <= DWrite;
            end else begin
                r_memAddr  <= IAddr;
                r_memRe    <= 1'b1;
                r_memWe    <= 1'b0;
            end
        end else if (w_done) begin
            r_memRe <= 1'b0;
            r_memWe <= 1'b0;
        end
    end

    // Response path: capture read data only while the read strobe is up
    // (the bus may float otherwise) and raise the owner's one-cycle Ack.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_iAck   <= 1'b0;
            r_dAck   <= 1'b0;
            r_iData  <= '0;
            r_dRData <= '0;
        end else begin
            r_iAck <= 1'b0;
            r_dAck <= 1'b0;
            if (w_done) begin
                if (r_owner == OWN_I) begin
                    r_iAck <= 1'b1;
                    if (r_memRe)
                        r_iData <= MemRData;
                end else begin
                    r_dAck <= 1'b1;
                    if (r_memRe)
                        r_dRData <= MemRData;
                end
            end
        end
    end

    assign IAck           = r_iAck;
    assign IData          = r_iData;
    assign DAck           = r_dAck;
    assign DRData         = r_dRData;
    assign MemAddr        = r_memAddr;
    assign MemWData       = r_memWData;
    assign MemReadEnable  = r_memRe;
    assign MemWriteEnable = r_memWe;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory with a ReadEnable/WriteEnable + Ack handshake between two requesters: the fetch port (I, read-only) and the load/store port (D, read/write).
- Sits between the pipeline's IF/MEM stages and the unified memory.
- Grants one transaction at a time, sequences the memory enables, captures the memory's combinational read data during its Ack cycle, and returns a registered one-cycle Ack to the granted requester.

Parameters:
- WIDTH, 32, data width in bits.
- ADDR_W, 32, byte-address width.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- IReq  in  1  fetch request; held with IAddr until IAck.
- IAddr  in  ADDR_W  fetch byte address.
- IAck  out  1  one-cycle pulse: IData valid.
- IData  out  WIDTH  fetched word, registered.
- DReq  in  1  data request; held with DAddr/DWrite/DWData until DAck.
- DWrite  in  1  1 = write, 0 = read.
- DAddr  in  ADDR_W  data byte address.
- DWData  in  WIDTH  write data.
- DAck  out  1  one-cycle pulse: DRData valid (read) or write done.
- DRData  out  WIDTH  read word, registered.
- MemAddr  out  ADDR_W  memory address.
- MemReadEnable  out  1  memory read strobe.
- MemWriteEnable  out  1  memory write strobe.
- MemWData  out  WIDTH  memory write data.
- MemRData  in  WIDTH  memory read data; valid only while MemReadEnable=1, may be Z otherwise.
- MemAck  in  1  memory completion pulse, arrives one cycle after the enable is first seen.

Behaviour:
- Reset (async, any state): state=IDLE; every output 0, including IData and DRData; LastGrant=I, so D wins the first conflict.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Neither request: stay in IDLE.
  - Exactly one request: latch its address, op and data into internal regs; record owner; go to ISSUE.
  - Both requests: grant the side not equal to LastGrant (round-robin).
- ISSUE, one cycle: MemAddr/MemWData driven from latched regs; MemReadEnable=1 for I or D-read; MemWriteEnable=1 for D-write. Go to WAIT.
- WAIT: keep enables and address asserted.
  - On MemAck=1: if read, capture MemRData into the owner's data register; go to RESP.
  - Enables drop on the clock edge that leaves WAIT, so the memory's Ack pulse is not retriggered.
- RESP: owner's Ack=1 for exactly one cycle; LastGrant<=owner; go to IDLE. All Mem* enables are 0.
- Latency:
  - Request seen in cycle 0 → ISSUE in cycle 1 → MemAck in cycle 2 → Ack in cycle 3.
  - Minimum 4 cycles between back-to-back grants.
- The requester may keep Req high in the cycle after Ack; this counts as a new request evaluated in IDLE.
- The non-granted requester sees no Ack; its Req and operands must stay stable. The arbiter does not latch it until granted.
- MemAck outside WAIT is ignored; this covers stale pulses after reset or a late memory.
- MemRData is sampled only in WAIT with MemAck=1 and MemReadEnable=1; never sample a Z bus.
- IData/DRData hold their last captured value between transactions. A write never changes DRData.
- Addresses pass through unmodified as byte addresses; word indexing is the memory's job.
- Requests that drop before grant are simply not served. Requests that drop after grant complete anyway; the Ack still pulses.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t
  - typedef enum logic {OWN_I, OWN_D} owner_t
- No sub-module needed. The grant decision is small enough to stay a local function, rr_pick(IReq, DReq, LastGrant).

Test Plan:
- Single fetch: IReq=1, IAddr=0x8, memory word 2 = 0x00221820 → MemReadEnable high in cycles 1–2, IAck=1 in cycle 3 with IData=0x00221820, DAck stays 0.
- Single write then read: DWrite=1, DAddr=0x10, DWData=0xDEADBEEF → DAck in cycle 3 with DRData unchanged (0). Then DWrite=0, same address → DAck with DRData=0xDEADBEEF.
- Simultaneous requests from reset: IReq=DReq=1 → D served first (DAck cycle 3), I served next (IAck cycle 7). Repeat both held → order alternates I, D.
- Back-to-back fetch: IReq held high, IAddr 0x0 then 0x4 → IAck in cycles 3 and 7 with words 0 and 1, exactly one memory enable window per fetch.
- Reset mid-WAIT: assert RST during WAIT → all outputs 0 immediately without a clock edge. The stale MemAck the next cycle produces no IAck/DAck, and the state stays IDLE.
- Z tolerance: drive MemRData=Z whenever enables are 0 → IData/DRData never become X.
